// File: rtl/in_switch_pkg.sv
// rtl/in_switch_pkg.sv - shared types and constants for the input switch
//
// Purpose: FSM state encoding, destination/drop constants and the saturating
//          drop counter increment used by in_switch.
// Ports:   none (package).
package in_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_DROP   = 2'd3;
  localparam int         NUM_OUT    = 3;
  localparam int         DROP_CNT_W = 16;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/in_switch_if.sv
// rtl/in_switch_if.sv - single stream channel (tdata/tvalid/tlast/tready)
//
// Purpose: bundles one stream channel.
// Modports: master drives tdata/tvalid/tlast and receives tready;
//           slave receives tdata/tvalid/tlast and drives tready.
interface in_switch_if #(
  parameter int DWIDTH = 128
);
  logic [DWIDTH-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/in_switch_skid.sv
// rtl/in_switch_skid.sv - 2-entry registered skid buffer
//
// Purpose: decouples one output stream from the switch input; every output
//          is driven from registers, and s_ready is itself a register.
// Ports:   clk, rst_n          clock, async active-low reset
//          s_data/s_valid      write side, s_ready high while < 2 entries held
//          m_data/m_valid      read side (head entry), m_ready downstream ready
module in_switch_skid #(
  parameter int WIDTH = 129
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] ent0;   // head, drives m_data
  logic [WIDTH-1:0] ent1;   // second entry, only valid when cnt == 2
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic             wr;
  logic             rd;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = ent0;
  assign wr      = s_valid & s_ready;
  assign rd      = m_valid & m_ready;

  always_comb begin
    cnt_nxt = cnt;
    case (cnt)
      2'd0:    cnt_nxt = wr ? 2'd1 : 2'd0;
      2'd1: begin
        if (wr && !rd)      cnt_nxt = 2'd2;
        else if (rd && !wr) cnt_nxt = 2'd0;
        else                cnt_nxt = 2'd1;
      end
      default: cnt_nxt = rd ? 2'd1 : 2'd2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0    <= '0;
      ent1    <= '0;
      cnt     <= 2'd0;
      s_ready <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      // Looking at the next occupancy keeps ready registered yet still
      // allows back-to-back beats when the head drains every cycle.
      s_ready <= (cnt_nxt != 2'd2);
      case (cnt)
        2'd0: if (wr) ent0 <= s_data;
        2'd1: begin
          if (wr && rd) ent0 <= s_data;  // head leaves, new beat takes its place
          else if (wr)  ent1 <= s_data;
        end
        default: if (rd) ent0 <= ent1;   // full: write is blocked by s_ready
      endcase
    end
  end

endmodule

// File: rtl/in_switch.sv
// rtl/in_switch.sv - 1-to-3 packet stream switch with drop destination
//
// Purpose: routes each packet arriving on s_axis to one of three outputs,
//          or discards it, according to sel sampled on the first beat.
// Ports:   clk, rst_n        clock, async active-low reset
//          s_axis (slave)    upstream stream
//          sel               destination for a new packet (3 = drop)
//          m_axis_0..2       downstream streams (master), each behind a skid
//          busy              a multi-beat packet is in progress
//          drop_cnt          saturating count of dropped packets
module in_switch
  import in_switch_pkg::*;
#(
  parameter int DWIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  in_switch_if.slave            s_axis,
  input  logic [1:0]            sel,
  in_switch_if.master           m_axis_0,
  in_switch_if.master           m_axis_1,
  in_switch_if.master           m_axis_2,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  state_t             state;
  logic   [1:0]       sel_q;
  logic   [1:0]       dest;
  logic               rdy_en;
  logic               dest_rdy;
  logic               acc;

  logic [NUM_OUT-1:0] wr;
  logic [NUM_OUT-1:0] sk_rdy;
  logic [NUM_OUT-1:0] m_vld;
  logic [NUM_OUT-1:0] m_rdy;
  logic [DWIDTH:0]    m_dat [NUM_OUT];

  // sel only matters on the first beat; mid-packet the latched copy wins.
  assign dest = (state == ST_IDLE) ? sel : sel_q;

  always_comb begin
    dest_rdy = 1'b1;
    case (dest)
      2'd0:    dest_rdy = sk_rdy[0];
      2'd1:    dest_rdy = sk_rdy[1];
      2'd2:    dest_rdy = sk_rdy[2];
      default: dest_rdy = 1'b1;   // drop sinks every beat
    endcase
  end

  // rdy_en holds tready low through reset even for the drop destination,
  // and lets it rise on the first edge after reset releases.
  assign s_axis.tready = rdy_en & dest_rdy;
  assign acc           = s_axis.tvalid & s_axis.tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel_q    <= 2'd0;
      busy     <= 1'b0;
      rdy_en   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (acc) begin
        if (s_axis.tlast) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (dest == SEL_DROP) drop_cnt <= sat_inc(drop_cnt);
        end else if (state == ST_IDLE) begin
          sel_q <= sel;
          state <= (sel == SEL_DROP) ? ST_DROP : ST_ROUTE;
          busy  <= 1'b1;
        end
      end
    end
  end

  assign m_rdy = {m_axis_2.tready, m_axis_1.tready, m_axis_0.tready};

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign wr[k] = acc && (dest == 2'(k));

    in_switch_skid #(
      .WIDTH (DWIDTH + 1)
    ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  ({s_axis.tlast, s_axis.tdata}),
      .s_valid (wr[k]),
      .s_ready (sk_rdy[k]),
      .m_data  (m_dat[k]),
      .m_valid (m_vld[k]),
      .m_ready (m_rdy[k])
    );
  end

  assign m_axis_0.tdata  = m_dat[0][DWIDTH-1:0];
  assign m_axis_0.tlast  = m_dat[0][DWIDTH];
  assign m_axis_0.tvalid = m_vld[0];
  assign m_axis_1.tdata  = m_dat[1][DWIDTH-1:0];
  assign m_axis_1.tlast  = m_dat[1][DWIDTH];
  assign m_axis_1.tvalid = m_vld[1];
  assign m_axis_2.tdata  = m_dat[2][DWIDTH-1:0];
  assign m_axis_2.tlast  = m_dat[2][DWIDTH];
  assign m_axis_2.tvalid = m_vld[2];

endmodule

// File: tb/tb_in_switch.sv
// tb/tb_in_switch.sv - self-checking bench for in_switch
module tb_in_switch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        busy;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  in_switch_if #(.DWIDTH(128)) s_if ();
  in_switch_if #(.DWIDTH(128)) m_if0 ();
  in_switch_if #(.DWIDTH(128)) m_if1 ();
  in_switch_if #(.DWIDTH(128)) m_if2 ();

  in_switch #(.DWIDTH(128)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_axis   (s_if),
    .sel      (sel),
    .m_axis_0 (m_if0),
    .m_axis_1 (m_if1),
    .m_axis_2 (m_if2),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  logic [2:0]   mv;
  logic [2:0]   ml;
  logic [127:0] md [3];
  assign mv    = {m_if2.tvalid, m_if1.tvalid, m_if0.tvalid};
  assign ml    = {m_if2.tlast, m_if1.tlast, m_if0.tlast};
  assign md[0] = m_if0.tdata;
  assign md[1] = m_if1.tdata;
  assign md[2] = m_if2.tdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  sel;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic [2:0]  mr;
    logic        srdy;
    logic [2:0]  mv;
    logic [2:0]  ml;
    logic [7:0]  md;
    logic        busy;
    logic [15:0] drop;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic v, input logic [7:0] d, input logic l);
    sel          = s;
    s_if.tvalid  = v;
    s_if.tdata   = 128'(d);
    s_if.tlast   = l;
  endtask

  task automatic set_mr(input logic [2:0] mr);
    m_if0.tready = mr[0];
    m_if1.tready = mr[1];
    m_if2.tready = mr[2];
  endtask

  logic [8:0] rx [$];
  int         idx;

  initial begin
    //        sel   v     d      l     mr      srdy  mv      ml      md     busy  drop
    vt[0]  = '{2'd1, 1'b1, 8'd1,  1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0, 16'd0};
    vt[1]  = '{2'd1, 1'b1, 8'd2,  1'b0, 3'b111, 1'b1, 3'b010, 3'b000, 8'd1,  1'b1, 16'd0};
    vt[2]  = '{2'd1, 1'b1, 8'd3,  1'b0, 3'b111, 1'b1, 3'b010, 3'b000, 8'd2,  1'b1, 16'd0};
    vt[3]  = '{2'd1, 1'b1, 8'd4,  1'b1, 3'b111, 1'b1, 3'b010, 3'b000, 8'd3,  1'b1, 16'd0};
    vt[4]  = '{2'd1, 1'b0, 8'd0,  1'b0, 3'b111, 1'b1, 3'b010, 3'b010, 8'd4,  1'b0, 16'd0};
    vt[5]  = '{2'd1, 1'b0, 8'd0,  1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0, 16'd0};
    vt[6]  = '{2'd1, 1'b1, 8'd11, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0, 16'd0};
    vt[7]  = '{2'd2, 1'b1, 8'd12, 1'b0, 3'b111, 1'b1, 3'b010, 3'b000, 8'd11, 1'b1, 16'd0};
    vt[8]  = '{2'd2, 1'b1, 8'd13, 1'b1, 3'b111, 1'b1, 3'b010, 3'b000, 8'd12, 1'b1, 16'd0};
    vt[9]  = '{2'd2, 1'b1, 8'd21, 1'b1, 3'b111, 1'b1, 3'b010, 3'b010, 8'd13, 1'b0, 16'd0};
    vt[10] = '{2'd2, 1'b0, 8'd0,  1'b0, 3'b111, 1'b1, 3'b100, 3'b100, 8'd21, 1'b0, 16'd0};
    vt[11] = '{2'd2, 1'b0, 8'd0,  1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0, 16'd0};
    vt[12] = '{2'd3, 1'b1, 8'd31, 1'b1, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0, 16'd0};
    vt[13] = '{2'd3, 1'b1, 8'd32, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0, 16'd1};
    vt[14] = '{2'd0, 1'b1, 8'd33, 1'b1, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b1, 16'd1};
    vt[15] = '{2'd3, 1'b1, 8'd34, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0, 16'd2};
    vt[16] = '{2'd1, 1'b1, 8'd35, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b1, 16'd2};
    vt[17] = '{2'd1, 1'b1, 8'd36, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b1, 16'd2};
    vt[18] = '{2'd1, 1'b1, 8'd37, 1'b1, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b1, 16'd2};
    vt[19] = '{2'd0, 1'b0, 8'd0,  1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 8'd0,  1'b0, 16'd3};

    // Reset state; sel=3 would make tready 1 if reset gating were missing.
    rst_n = 1'b0;
    drive(2'd3, 1'b1, 8'd0, 1'b0);
    set_mr(3'b111);
    #1;
    chk("rst_tready", 128'(s_if.tready), 128'(0));
    chk("rst_mvalid", 128'(mv), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_drop", 128'(drop_cnt), 128'(0));
    chk("rst_tdata1", md[1], 128'(0));
    chk("rst_tlast", 128'(ml), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd0, 1'b0, 8'd0, 1'b0);
    #1;
    chk("rel_tready_before_edge", 128'(s_if.tready), 128'(0));

    // Routing, sel latching and drop counting, one row per cycle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vt[i].sel, vt[i].v, vt[i].d, vt[i].l);
      set_mr(vt[i].mr);
      #1;
      chk($sformatf("v%0d_tready", i), 128'(s_if.tready), 128'(vt[i].srdy));
      chk($sformatf("v%0d_mvalid", i), 128'(mv), 128'(vt[i].mv));
      chk($sformatf("v%0d_mlast", i), 128'(ml & mv), 128'(vt[i].ml));
      chk($sformatf("v%0d_busy", i), 128'(busy), 128'(vt[i].busy));
      chk($sformatf("v%0d_drop", i), 128'(drop_cnt), 128'(vt[i].drop));
      for (int k = 0; k < 3; k++)
        if (vt[i].mv[k]) chk($sformatf("v%0d_mdata%0d", i, k), md[k], 128'(vt[i].md));
    end

    // Backpressure on output 0: two beats fill the skid, then tready drops.
    set_mr(3'b110);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(2'd0, 1'b1, 8'(41 + idx), idx == 4);
      #1;
      if (s_if.tready) idx++;
    end
    @(negedge clk);
    drive(2'd0, 1'b1, 8'(41 + idx), idx == 4);
    #1;
    chk("bp_accepted", 128'(idx), 128'(2));
    chk("bp_tready", 128'(s_if.tready), 128'(0));
    chk("bp_busy", 128'(busy), 128'(1));
    chk("bp_mvalid0", 128'(mv), 128'(3'b001));
    chk("bp_head", md[0], 128'(41));
    for (int c = 0; c < 30 && rx.size() < 5; c++) begin
      @(negedge clk);
      drive(2'd0, idx < 5, 8'(41 + idx), idx == 4);
      set_mr(3'b111);
      #1;
      if (m_if0.tvalid) rx.push_back({m_if0.tlast, m_if0.tdata[7:0]});
      if (s_if.tready && idx < 5) idx++;
    end
    chk("bp_rx_count", 128'(rx.size()), 128'(5));
    for (int i = 0; i < rx.size() && i < 5; i++)
      chk($sformatf("bp_rx%0d", i), 128'(rx[i]), 128'({i == 4, 8'(41 + i)}));
    @(negedge clk);
    drive(2'd0, 1'b0, 8'd0, 1'b0);
    #1;
    chk("bp_drained", 128'(mv), 128'(0));
    chk("bp_idle", 128'(busy), 128'(0));

    // Reset mid-packet with two beats held in output 2.
    set_mr(3'b011);
    @(negedge clk); drive(2'd2, 1'b1, 8'd51, 1'b0);
    @(negedge clk); drive(2'd2, 1'b1, 8'd52, 1'b0);
    @(negedge clk); drive(2'd2, 1'b1, 8'd53, 1'b0);
    #1;
    chk("mr_full_tready", 128'(s_if.tready), 128'(0));
    chk("mr_full_mvalid", 128'(mv), 128'(3'b100));
    chk("mr_full_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mr_rst_mvalid2", 128'(m_if2.tvalid), 128'(0));
    chk("mr_rst_tdata2", md[2], 128'(0));
    chk("mr_rst_busy", 128'(busy), 128'(0));
    chk("mr_rst_tready", 128'(s_if.tready), 128'(0));
    chk("mr_rst_drop", 128'(drop_cnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    set_mr(3'b111);
    drive(2'd0, 1'b1, 8'd61, 1'b1);
    #1;
    chk("mr_rel_tready0", 128'(s_if.tready), 128'(0));
    @(negedge clk);
    #1;
    chk("mr_rel_tready1", 128'(s_if.tready), 128'(1));
    @(negedge clk);
    drive(2'd0, 1'b0, 8'd0, 1'b0);
    #1;
    chk("mr_new_mvalid", 128'(mv), 128'(3'b001));
    chk("mr_new_data", md[0], 128'(61));
    chk("mr_new_last", 128'(m_if0.tlast), 128'(1));
    chk("mr_new_busy", 128'(busy), 128'(0));

    // Drop counter saturation: 0xFFFE single-beat drops, then three more.
    @(negedge clk);
    drive(2'd3, 1'b1, 8'd0, 1'b1);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    drive(2'd0, 1'b0, 8'd0, 1'b0);
    #1;
    chk("sat_fffe", 128'(drop_cnt), 128'(16'hFFFE));
    chk("sat_no_mvalid", 128'(mv), 128'(0));
    @(negedge clk);
    drive(2'd3, 1'b1, 8'd0, 1'b1);
    #1;
    chk("sat_tready", 128'(s_if.tready), 128'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(2'd0, 1'b0, 8'd0, 1'b0);
    #1;
    chk("sat_ffff", 128'(drop_cnt), 128'(16'hFFFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
